// File: rtl/stopwatch_reader_if.sv
// ---------------------------------------------------------------------------
// stopwatch_reader_if
// Bundles the two handshake groups used by the stopwatch reader:
//   - Avalon-MM read side towards the stopwatch slave:
//       avalon_read       read strobe (driven by the reader)
//       avalon_readdata   ADW-bit read data, combinational from the slave
//       avalon_interrupt  level-sensitive timepoint pending flag
//   - ready/valid result stream towards a UART or logger:
//       o_valid, o_ready  stream handshake
//       o_tmp, o_err      timepoint flag and illegal-BCD flag of the head entry
//       o_ms              22-bit elapsed time in milliseconds
// modport master: the reader's view. modport slave: the stopwatch/sink view.
// ---------------------------------------------------------------------------
interface stopwatch_reader_if #(
    parameter int ADW = 32
) ();
    logic           avalon_read;
    logic [ADW-1:0] avalon_readdata;
    logic           avalon_interrupt;
    logic           o_valid;
    logic           o_ready;
    logic           o_tmp;
    logic           o_err;
    logic [21:0]    o_ms;

    modport master (
        output avalon_read,
        input  avalon_readdata,
        input  avalon_interrupt,
        output o_valid,
        input  o_ready,
        output o_tmp,
        output o_err,
        output o_ms
    );

    modport slave (
        input  avalon_read,
        output avalon_readdata,
        output avalon_interrupt,
        input  o_valid,
        output o_ready,
        input  o_tmp,
        input  o_err,
        input  o_ms
    );
endinterface

// File: rtl/stopwatch_reader.sv
// ---------------------------------------------------------------------------
// stopwatch_reader
// Avalon-MM read master for the stopwatch timer. A read is issued whenever
// the stopwatch raises its timepoint interrupt or, optionally, when the poll
// counter expires. The packed BCD readout is validated and converted to
// binary milliseconds by a 7-step Horner accumulation, then queued in a small
// first-word-fall-through FIFO that feeds a ready/valid stream.
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset
//   enable  enables the poll counter and new read requests
//   bus     stopwatch_reader_if.master (Avalon read side + result stream)
//   ovf     one-cycle pulse when a result is dropped because the FIFO is full
//   level   FIFO occupancy
// ---------------------------------------------------------------------------
module stopwatch_reader #(
    parameter int ADW    = 32,
    parameter int POLL   = 1000,
    parameter int FDEPTH = 4,
    parameter int FAW    = $clog2(FDEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    stopwatch_reader_if.master        bus,
    output logic                      ovf,
    output logic [FAW:0]              level
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_CONV = 3'd2;
    localparam logic [2:0] S_PUSH = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [FAW:0] FULL_COUNT = (FAW+1)'(FDEPTH);

    logic [2:0]     state;
    logic [2:0]     state_next;
    logic           poll_pending;
    logic           request;
    logic [ADW-1:0] cap;
    logic [2:0]     step;
    logic [3:0]     digit;
    logic           digit_bad;
    logic [21:0]    mult;
    logic [21:0]    acc;
    logic           err;
    logic [23:0]    mem [FDEPTH];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic [FAW:0]   count;
    logic           head_valid;
    logic           full;
    logic           push;
    logic           pop;
    logic           unused_cap;

    // Reserved readdata bits are captured with the rest of the word but
    // never decoded.
    assign unused_cap = ^cap;

    // The interrupt and a pending poll are both plain read requests; the
    // interrupt's priority only matters in that either one clears the poll.
    assign request = enable && (bus.avalon_interrupt || poll_pending);

    // Poll counter: expiries while the FSM is busy collapse into one pending
    // flag. An expiry in the READ cycle itself wins over the clear so that
    // it is not lost.
    generate
        if (POLL != 0) begin : g_poll
            localparam int PCW = (POLL > 1) ? $clog2(POLL) : 1;
            localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL - 1);
            logic [PCW-1:0] poll_cnt;
            logic           expire;

            assign expire = enable && (poll_cnt == POLL_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    poll_cnt     <= '0;
                    poll_pending <= 1'b0;
                end else begin
                    if (enable) begin
                        poll_cnt <= expire ? '0 : poll_cnt + 1'b1;
                    end
                    if (expire) begin
                        poll_pending <= 1'b1;
                    end else if (state == S_READ) begin
                        poll_pending <= 1'b0;
                    end
                end
            end
        end else begin : g_no_poll
            assign poll_pending = 1'b0;
        end
    endgenerate

    // Sequencer: IDLE -> READ -> CONV (7 cycles) -> PUSH -> GAP -> IDLE.
    // GAP gives the slave one cycle to drop its interrupt after the read.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (request) state_next = S_READ;
            S_READ: state_next = S_CONV;
            S_CONV: if (step == 3'd6) state_next = S_PUSH;
            S_PUSH: state_next = S_GAP;
            S_GAP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign bus.avalon_read = (state == S_READ);

    // Digit feeding the current Horner step, most significant first.
    always_comb begin
        digit = cap[3:0];
        case (step)
            3'd0: digit = cap[27:24];
            3'd1: digit = cap[23:20];
            3'd2: digit = cap[19:16];
            3'd3: digit = cap[15:12];
            3'd4: digit = cap[11:8];
            3'd5: digit = cap[7:4];
            default: digit = cap[3:0];
        endcase
    end

    // Tens-of-minutes and tens-of-seconds digits only go up to 5.
    assign digit_bad = (digit > 4'd9) ||
                       (((step == 3'd0) || (step == 3'd2)) && (digit > 4'd5));

    // sec_1 enters with a x6 weight (minutes -> tens of seconds); every
    // other step is a decimal shift.
    assign mult = (step == 3'd2) ? 22'd6 : 22'd10;

    // Capture on the read, then accumulate one digit per CONV cycle while
    // the legality check runs alongside. Step 0 reloads both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap  <= '0;
            step <= 3'd0;
            acc  <= 22'd0;
            err  <= 1'b0;
        end else if (state == S_READ) begin
            cap  <= bus.avalon_readdata;
            step <= 3'd0;
        end else if (state == S_CONV) begin
            step <= step + 3'd1;
            if (step == 3'd0) begin
                acc <= {18'd0, digit};
                err <= digit_bad;
            end else begin
                acc <= acc * mult + {18'd0, digit};
                err <= err | digit_bad;
            end
        end
    end

    // FIFO control. A pop in the PUSH cycle frees a slot, so a push into a
    // full FIFO is still accepted in that case.
    assign head_valid = (count != '0);
    assign full       = (count == FULL_COUNT);
    assign pop        = head_valid && bus.o_ready;
    assign push       = (state == S_PUSH) && (!full || pop);
    assign ovf        = (state == S_PUSH) && full && !pop;

    // Storage is not reset; the outputs below are gated by head_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cap[ADW-1], err, (err ? 22'd0 : acc)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign level       = count;
    assign bus.o_valid = head_valid;
    assign {bus.o_tmp, bus.o_err, bus.o_ms} = head_valid ? mem[rd_ptr] : 24'd0;

endmodule

// File: tb/tb_stopwatch_reader.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_reader
// Scoreboard bench for stopwatch_reader. dut_a runs without polling and is
// driven by interrupts; dut_b polls every 20 cycles. Expected stream entries
// {tmp, err, ms} are queued when a readout is handed to a DUT and popped by
// a per-DUT monitor at every stream handshake.
// ---------------------------------------------------------------------------
module tb_stopwatch_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_a;
    logic       enable_b;
    logic       ovf_a;
    logic       ovf_b;
    logic [2:0] level_a;
    logic [2:0] level_b;

    stopwatch_reader_if #(.ADW(32)) bus_a ();
    stopwatch_reader_if #(.ADW(32)) bus_b ();

    stopwatch_reader #(.ADW(32), .POLL(0), .FDEPTH(4)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .enable (enable_a),
        .bus    (bus_a.master),
        .ovf    (ovf_a),
        .level  (level_a)
    );

    stopwatch_reader #(.ADW(32), .POLL(20), .FDEPTH(4)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .enable (enable_b),
        .bus    (bus_b.master),
        .ovf    (ovf_b),
        .level  (level_b)
    );

    always #5 clk = ~clk;

    int          assertions = 0;
    int          failures   = 0;
    int          ovf_seen_a = 0;
    int          ovf_seen_b = 0;
    logic [23:0] sb_a [$];
    logic [23:0] sb_b [$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic monitorA();
        logic [23:0] exp_entry;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ovf_a) ovf_seen_a++;
                if (bus_a.o_valid && bus_a.o_ready) begin
                    if (sb_a.size() == 0) begin
                        assertions++;
                        failures++;
                        $display("[TB] FAIL outA: unexpected entry ms=%0d, expected none", bus_a.o_ms);
                    end else begin
                        exp_entry = sb_a.pop_front();
                        checkOutput("outA", int'({bus_a.o_tmp, bus_a.o_err, bus_a.o_ms}), int'(exp_entry));
                    end
                end
            end
        end
    endtask

    task automatic monitorB();
        logic [23:0] exp_entry;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ovf_b) ovf_seen_b++;
                if (bus_b.o_valid && bus_b.o_ready) begin
                    if (sb_b.size() == 0) begin
                        assertions++;
                        failures++;
                        $display("[TB] FAIL outB: unexpected entry ms=%0d, expected none", bus_b.o_ms);
                    end else begin
                        exp_entry = sb_b.pop_front();
                        checkOutput("outB", int'({bus_b.o_tmp, bus_b.o_err, bus_b.o_ms}), int'(exp_entry));
                    end
                end
            end
        end
    endtask

    // Raises the interrupt on dut_a with the given readout, acts as the
    // slave by dropping the interrupt one edge after the read, and returns
    // at the start of the IDLE cycle following GAP. Cycle 0 is the first
    // cycle in which the interrupt is visible. Must be called just after a
    // rising edge.
    task automatic applyStimulus(input logic [31:0] data, output int read_at,
                                 output int read_cycles, output int valid_at);
        bus_a.avalon_readdata  = data;
        bus_a.avalon_interrupt = 1'b1;
        read_at     = -1;
        read_cycles = 0;
        valid_at    = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus_a.o_valid && valid_at < 0) valid_at = n;
            if (bus_a.avalon_read) begin
                read_cycles++;
                if (read_at < 0) read_at = n;
            end
            if (read_at >= 0 && n == read_at + 9) break;
            if (read_at >= 0 && bus_a.avalon_interrupt) begin
                @(posedge clk);
                #1 bus_a.avalon_interrupt = 1'b0;
            end
        end
        if (read_at < 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL readTimeoutA: got no read, expected one within 40 cycles");
            bus_a.avalon_interrupt = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          ra;
        int          rc;
        int          va;
        int          ovf0;
        int          reads [$];
        logic [23:0] exp_b;
        bit          irq_done;

        rst                    = 1'b1;
        enable_a               = 1'b0;
        enable_b               = 1'b0;
        bus_a.avalon_readdata  = '0;
        bus_a.avalon_interrupt = 1'b0;
        bus_a.o_ready          = 1'b1;
        bus_b.avalon_readdata  = '0;
        bus_b.avalon_interrupt = 1'b0;
        bus_b.o_ready          = 1'b1;
        exp_b                  = '0;
        irq_done               = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rstReadA",  int'(bus_a.avalon_read), 0);
        checkOutput("rstValidA", int'(bus_a.o_valid), 0);
        checkOutput("rstTmpA",   int'(bus_a.o_tmp), 0);
        checkOutput("rstErrA",   int'(bus_a.o_err), 0);
        checkOutput("rstMsA",    int'(bus_a.o_ms), 0);
        checkOutput("rstOvfA",   int'(ovf_a), 0);
        checkOutput("rstLevelA", int'(level_a), 0);
        checkOutput("rstReadB",  int'(bus_b.avalon_read), 0);
        checkOutput("rstValidB", int'(bus_b.o_valid), 0);

        rst = 1'b0;
        fork
            monitorA();
            monitorB();
        join_none
        enable_a = 1'b1;
        @(posedge clk);
        #1;

        // Timepoint read: 01:23.456 -> 83456 ms, read 1 cycle, valid at 10
        sb_a.push_back({1'b1, 1'b0, 22'd83456});
        applyStimulus(32'h80123456, ra, rc, va);
        checkOutput("tpReadAt",    ra, 1);
        checkOutput("tpReadCycles", rc, 1);
        checkOutput("tpValidAt",   va, 10);

        // 10:00.000 exercises min_1; all-zero readout is the lower bound
        sb_a.push_back({1'b0, 1'b0, 22'd600000});
        applyStimulus(32'h01000000, ra, rc, va);
        sb_a.push_back({1'b0, 1'b0, 22'd0});
        applyStimulus(32'h00000000, ra, rc, va);

        // Illegal BCD: mil_0=A, sec_1=6, min_1=6
        sb_a.push_back({1'b0, 1'b1, 22'd0});
        applyStimulus(32'h0012345A, ra, rc, va);
        sb_a.push_back({1'b0, 1'b1, 22'd0});
        applyStimulus(32'h00163456, ra, rc, va);
        sb_a.push_back({1'b1, 1'b1, 22'd0});
        applyStimulus(32'h86000000, ra, rc, va);

        // FIFO full: four entries fit, the fifth is dropped with one ovf
        bus_a.o_ready = 1'b0;
        ovf0 = ovf_seen_a;
        sb_a.push_back({1'b1, 1'b0, 22'd1});
        applyStimulus(32'h80000001, ra, rc, va);
        sb_a.push_back({1'b0, 1'b0, 22'd10});
        applyStimulus(32'h00000010, ra, rc, va);
        sb_a.push_back({1'b1, 1'b0, 22'd1000});
        applyStimulus(32'h80001000, ra, rc, va);
        sb_a.push_back({1'b0, 1'b0, 22'd10000});
        applyStimulus(32'h00010000, ra, rc, va);
        checkOutput("fullLevel4", int'(level_a), 4);
        checkOutput("fullNoOvf",  ovf_seen_a - ovf0, 0);
        applyStimulus(32'h80100000, ra, rc, va);
        checkOutput("fullLevelStill4", int'(level_a), 4);
        checkOutput("fullOvfOnce",     ovf_seen_a - ovf0, 1);
        bus_a.o_ready = 1'b1;
        for (int n = 0; n < 20 && level_a != 3'd0; n++) @(posedge clk);
        #1;
        checkOutput("drainLevel", int'(level_a), 0);
        checkOutput("drainSb",    sb_a.size(), 0);

        // Reset mid-CONV with one entry already held in the FIFO
        bus_a.o_ready = 1'b0;
        applyStimulus(32'h00000005, ra, rc, va);
        checkOutput("preRstLevel", int'(level_a), 1);
        bus_a.avalon_readdata  = 32'h00000123;
        bus_a.avalon_interrupt = 1'b1;
        ra = -1;
        for (int n = 0; n < 40 && ra < 0; n++) begin
            @(negedge clk);
            if (bus_a.avalon_read) ra = n;
        end
        checkOutput("rstTestRead", ra, 1);
        @(posedge clk);
        #1 bus_a.avalon_interrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midRstRead",  int'(bus_a.avalon_read), 0);
        checkOutput("midRstValid", int'(bus_a.o_valid), 0);
        checkOutput("midRstTmp",   int'(bus_a.o_tmp), 0);
        checkOutput("midRstMs",    int'(bus_a.o_ms), 0);
        checkOutput("midRstLevel", int'(level_a), 0);
        checkOutput("midRstOvf",   int'(ovf_a), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus_a.o_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("postRstLevel", int'(level_a), 0);
        sb_a.push_back({1'b0, 1'b0, 22'd123});
        applyStimulus(32'h00000123, ra, rc, va);
        checkOutput("postRstReadAt", ra, 1);
        checkOutput("postRstValidAt", va, 10);

        // Poll: 59:59.999 every 20 cycles, then interrupt coinciding with
        // a poll expiry must produce a single read
        bus_b.avalon_readdata = 32'h05959999;
        exp_b    = {1'b0, 1'b0, 22'd3599999};
        enable_b = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus_b.avalon_read) begin
                reads.push_back(n);
                sb_b.push_back(exp_b);
                if (bus_b.avalon_interrupt) begin
                    @(posedge clk);
                    #1;
                    bus_b.avalon_interrupt = 1'b0;
                    bus_b.avalon_readdata  = 32'h00000777;
                    exp_b = {1'b0, 1'b0, 22'd777};
                end
            end
            if (reads.size() == 3 && !irq_done && n == reads[2] + 18) begin
                @(posedge clk);
                #1;
                bus_b.avalon_interrupt = 1'b1;
                bus_b.avalon_readdata  = 32'h80000042;
                exp_b    = {1'b1, 1'b0, 22'd42};
                irq_done = 1'b1;
            end
            if (reads.size() == 5 && n == reads[4] + 12) break;
        end
        enable_b = 1'b0;
        checkOutput("pollReads", reads.size(), 5);
        if (reads.size() == 5) begin
            checkOutput("pollFirstAt", reads[0], 21);
            checkOutput("pollGap01", reads[1] - reads[0], 20);
            checkOutput("pollGap12", reads[2] - reads[1], 20);
            checkOutput("mergeGap23", reads[3] - reads[2], 20);
            checkOutput("mergeGap34", reads[4] - reads[3], 20);
        end

        for (int n = 0; n < 30 && (sb_a.size() != 0 || sb_b.size() != 0); n++) @(posedge clk);
        #1;
        checkOutput("sbEmptyA", sb_a.size(), 0);
        checkOutput("sbEmptyB", sb_b.size(), 0);
        checkOutput("ovfNoneB", ovf_seen_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
